// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan controller.
// Anode patterns are active-low: a 0 bit lights that digit.
package display_scan_ctrl_pkg;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [3:0] ANODE_DIG [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  function automatic logic [3:0] digit_anode(input logic [1:0] idx, input logic [3:0] mask);
    return mask[idx] ? ANODE_DIG[idx] : ANODE_OFF;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle between the arithmetic datapath (operands in), the scan controller,
// and the seven-segment decoders (anode select and committed values out).
interface display_scan_ctrl_if;

  logic       en;
  logic       load;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] sum_in;
  logic [3:0] diff_in;
  logic [3:0] digit_mask;
  logic [3:0] anode;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [3:0] sum_out;
  logic [3:0] diff_out;
  logic       frame_tick;

  modport master (
    output en, load, a_in, b_in, sum_in, diff_in, digit_mask,
    input  anode, a_out, b_out, sum_out, diff_out, frame_tick
  );

  modport slave (
    input  en, load, a_in, b_in, sum_in, diff_in, digit_mask,
    output anode, a_out, b_out, sum_out, diff_out, frame_tick
  );

endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
// A load value of N-1 therefore yields a slot of N cycles.
module scan_timer #(
  parameter int              CNT_W   = 1,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed anode scan for a 4-digit common-anode display with blanking
// gaps, plus shadow/commit registers so the decoders see frame-coherent values.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_LD = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);
  // With no blanking the ON slot chains straight into the next ON slot.
  localparam logic [CNT_W-1:0] AFTER_ON_LD = (BLANK_CYCLES == 0) ? ON_LD : BLK_LD;

  scan_state_t      r_state;
  logic [1:0]       r_idx;
  logic [3:0]       r_anode;
  logic             r_tick;
  logic [15:0]      r_shadow;
  logic [15:0]      r_vals;

  logic             w_tc;
  logic             w_ld;
  logic [CNT_W-1:0] w_ld_val;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_in;
  logic [15:0]      w_commit;

  assign w_idx_nxt = r_idx + 2'd1;
  assign w_in      = {bus.a_in, bus.b_in, bus.sum_in, bus.diff_in};
  // A load landing on the commit edge wins over the stale shadow.
  assign w_commit  = bus.load ? w_in : r_shadow;

  always_comb begin
    w_ld     = 1'b0;
    w_ld_val = BLK_LD;
    if (!bus.en) begin
      w_ld     = 1'b1;
      w_ld_val = BLK_LD;
    end else if (w_tc) begin
      w_ld     = 1'b1;
      w_ld_val = (r_state == BLANK) ? ON_LD : AFTER_ON_LD;
    end
  end

  scan_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (BLK_LD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_ld),
    .i_val  (w_ld_val),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= BLANK;
      r_idx    <= 2'd0;
      r_anode  <= ANODE_OFF;
      r_tick   <= 1'b0;
      r_shadow <= '0;
      r_vals   <= '0;
    end else begin
      if (bus.load) begin
        r_shadow <= w_in;
      end
      r_tick <= 1'b0;
      if (!bus.en) begin
        r_state <= BLANK;
        r_idx   <= 2'd0;
        r_anode <= ANODE_OFF;
      end else begin
        case (r_state)
          BLANK: begin
            if (w_tc) begin
              r_state <= ON;
              r_anode <= digit_anode(r_idx, bus.digit_mask);
            end else begin
              r_anode <= ANODE_OFF;
            end
          end
          ON: begin
            if (w_tc) begin
              r_idx <= w_idx_nxt;
              if (r_idx == 2'd3) begin
                r_tick <= 1'b1;
                r_vals <= w_commit;
              end
              if (BLANK_CYCLES == 0) begin
                r_anode <= digit_anode(w_idx_nxt, bus.digit_mask);
              end else begin
                r_state <= BLANK;
                r_anode <= ANODE_OFF;
              end
            end else begin
              r_anode <= digit_anode(r_idx, bus.digit_mask);
            end
          end
        endcase
      end
    end
  end

  assign bus.anode      = r_anode;
  assign bus.frame_tick = r_tick;
  assign bus.a_out      = r_vals[15:12];
  assign bus.b_out      = r_vals[11:8];
  assign bus.sum_out    = r_vals[7:4];
  assign bus.diff_out   = r_vals[3:0];

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: expected anode/tick/value triples are
// queued per cycle as stimulus is driven and popped as the DUTs clock.
module tb_display_scan_ctrl;

  localparam int D = 4;
  localparam int B = 2;
  localparam logic [3:0] AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic [3:0]  an;
    logic        tk;
    logic [15:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  display_scan_ctrl_if bus1();
  display_scan_ctrl_if bus0();

  display_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  display_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input int idx, input logic [3:0] m);
    return m[idx] ? AN[idx] : 4'b1111;
  endfunction

  task automatic push(input bit d0, input logic [3:0] an, input logic tk, input logic [15:0] v);
    exp_t e;
    e.an = an;
    e.tk = tk;
    e.v  = v;
    if (d0) q0.push_back(e);
    else    q1.push_back(e);
  endtask

  task automatic push_slot(input bit d0, input int idx, input logic [3:0] m, input int nb,
                           input logic tk, input logic [15:0] v);
    for (int i = 0; i < nb; i++) push(d0, 4'b1111, tk && (i == 0), v);
    for (int i = 0; i < D; i++) push(d0, exp_an(idx, m), tk && (nb == 0) && (i == 0), v);
  endtask

  // First frame after reset or en rising: the cycle before the first sampled edge is already blank.
  task automatic push_startup(input bit d0, input logic [3:0] m, input int nb, input logic [15:0] v);
    for (int i = 0; i < nb - 1; i++) push(d0, 4'b1111, 1'b0, v);
    for (int i = 0; i < D; i++) push(d0, exp_an(0, m), 1'b0, v);
    for (int s = 1; s < 4; s++) push_slot(d0, s, m, nb, 1'b0, v);
  endtask

  task automatic push_frame(input bit d0, input logic [3:0] m, input int nb, input logic [15:0] v);
    push_slot(d0, 0, m, nb, 1'b1, v);
    for (int s = 1; s < 4; s++) push_slot(d0, s, m, nb, 1'b0, v);
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("anode", bus1.anode, e.an);
        chk("frame_tick", bus1.frame_tick, e.tk);
        chk("values", {bus1.a_out, bus1.b_out, bus1.sum_out, bus1.diff_out}, e.v);
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("anode_noblank", bus0.anode, e.an);
        chk("frame_tick_noblank", bus0.frame_tick, e.tk);
        chk("values_noblank", {bus0.a_out, bus0.b_out, bus0.sum_out, bus0.diff_out}, e.v);
      end
    end
  endtask

  task automatic drive_in(input logic [15:0] v);
    {bus1.a_in, bus1.b_in, bus1.sum_in, bus1.diff_in} = v;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus1.en         = 1'b1;
    bus1.load       = 1'b0;
    bus1.digit_mask = 4'b1111;
    drive_in(16'h0000);
    bus0.en         = 1'b0;
    bus0.load       = 1'b0;
    bus0.digit_mask = 4'b1111;
    {bus0.a_in, bus0.b_in, bus0.sum_in, bus0.diff_in} = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_anode", bus1.anode, 4'b1111);
    chk("reset_tick", bus1.frame_tick, 1'b0);
    chk("reset_values", {bus1.a_out, bus1.b_out, bus1.sum_out, bus1.diff_out}, 16'h0000);
    chk("reset_anode_noblank", bus0.anode, 4'b1111);

    // Free-running scan: startup frame plus one full frame.
    push_startup(1'b0, 4'b1111, B, 16'h0000);
    push_frame(1'b0, 4'b1111, B, 16'h0000);
    run(47);

    // Mid-frame load stays hidden until the next commit.
    push_frame(1'b0, 4'b1111, B, 16'h0000);
    run(10);
    drive_in(16'h358E);
    bus1.load = 1'b1;
    run(1);
    bus1.load = 1'b0;
    run(13);
    push_frame(1'b0, 4'b1111, B, 16'h358E);
    run(24);

    // Load coinciding with the commit edge.
    drive_in(16'h7186);
    bus1.load = 1'b1;
    push_frame(1'b0, 4'b1111, B, 16'h7186);
    run(1);
    bus1.load = 1'b0;
    drive_in(16'h0000);
    run(23);

    // Masked digits; the commit here also proves the shadow took the coincident load.
    bus1.digit_mask = 4'b1010;
    push_frame(1'b0, 4'b1010, B, 16'h7186);
    run(24);

    // Drop enable during the idx2 ON slot, load while dark, then restart.
    bus1.digit_mask = 4'b1111;
    push_slot(1'b0, 0, 4'b1111, B, 1'b1, 16'h7186);
    push_slot(1'b0, 1, 4'b1111, B, 1'b0, 16'h7186);
    push(1'b0, 4'b1111, 1'b0, 16'h7186);
    push(1'b0, 4'b1111, 1'b0, 16'h7186);
    push(1'b0, AN[2], 1'b0, 16'h7186);
    push(1'b0, AN[2], 1'b0, 16'h7186);
    run(16);
    bus1.en   = 1'b0;
    bus1.load = 1'b1;
    drive_in(16'h92B7);
    push(1'b0, 4'b1111, 1'b0, 16'h7186);
    run(1);
    bus1.load = 1'b0;
    drive_in(16'h0000);
    push(1'b0, 4'b1111, 1'b0, 16'h7186);
    push(1'b0, 4'b1111, 1'b0, 16'h7186);
    run(2);
    bus1.en = 1'b1;
    push_startup(1'b0, 4'b1111, B, 16'h7186);
    push_frame(1'b0, 4'b1111, B, 16'h92B7);
    run(47);

    // No-blanking instance: 16-cycle frames, never dark with full mask.
    bus0.en = 1'b1;
    push_startup(1'b1, 4'b1111, 0, 16'h0000);
    push_frame(1'b1, 4'b1111, 0, 16'h0000);
    run(32);
    push(1'b1, AN[0], 1'b1, 16'h0000);
    push(1'b1, AN[0], 1'b0, 16'h0000);
    run(2);
    chk("q1_drained", q1.size(), 0);
    chk("q0_drained", q0.size(), 0);

    // Asynchronous reset while a digit is lit.
    rst_n = 1'b0;
    #1;
    chk("async_rst_anode_noblank", bus0.anode, 4'b1111);
    chk("async_rst_anode", bus1.anode, 4'b1111);
    chk("async_rst_tick_noblank", bus0.frame_tick, 1'b0);
    chk("async_rst_values", {bus1.a_out, bus1.b_out, bus1.sum_out, bus1.diff_out}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
